axi4full_burst_master: RTL and testbench
========================================

Name: axi4full_burst_master

Overview:
- Per-client AXI4-full burst master that converts a simple cache/LSU request interface into AXI4 bursts.
- Sits directly upstream of the 2x1 AXI4-full arbiter: one instance feeds port A (ifetch, reads only), another feeds port B (data, reads and writes).
- Generates AR/AW/W/B/R handshakes, counts beats, drives WLAST and checks RLAST against the requested length.
- ID fields are not driven here; the arbiter inserts them.

Parameters:
- DATA_WIDTH, 64, width of the data bus in bits.
- ADDR_WIDTH, 32, width of the address bus in bits.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.

Ports:
- i_aclk  in  1  clock
- i_arsetn  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  client request valid
- o_req_ready  out  1  request accepted; high only in IDLE
- i_req_write  in  1  1 = write burst, 0 = read burst
- i_req_addr  in  ADDR_WIDTH  start address
- i_req_len  in  8  beats minus 1 (AXI LEN encoding)
- i_req_size  in  3  bytes per beat, log2
- i_cw_data  in  DATA_WIDTH  client write beat
- i_cw_strb  in  STRB_WIDTH  client write strobe
- i_cw_valid  in  1  client write beat valid
- o_cw_ready  out  1  client write beat consumed
- o_cr_data  out  DATA_WIDTH  read beat to client
- o_cr_valid  out  1  read beat valid
- o_cr_last  out  1  final read beat
- i_cr_ready  in  1  client accepts read beat
- o_done  out  1  one-cycle pulse at transaction end
- o_err  out  1  qualifies o_done; high when the transaction failed
- AXI master side, as consumed by the arbiter A/B ports:
  - o_awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid, i_awready
  - o_wdata/wstrb/wlast/wvalid, i_wready
  - i_bresp, i_bvalid, o_bready
  - o_araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid, i_arready
  - i_rdata, i_rresp, i_rlast, i_rvalid, o_rready

Behaviour:
- Reset (i_arsetn low, async): state=IDLE, beat counter=0, error flag=0.
  - Outputs 0: o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_cr_valid, o_cw_ready, o_done, o_err.
  - Address/len/size registers 0.
  - Reset mid-burst abandons the transaction silently; no o_done.
- Constant fields: awburst/arburst=2'b01 (INCR); lock, cache, prot = 0.
- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid, latch addr/len/size and clear counter and error flag.
  - Next state: AW if i_req_write, else AR.
- AR:
  - o_arvalid=1 from registered signals, held stable until i_arready.
  - i_arready -> R.
- R:
  - Pure combinational pass-through, no added latency: o_cr_data=i_rdata, o_cr_valid=i_rvalid, o_rready=i_cr_ready.
  - o_cr_last = (counter==len).
  - On each beat (i_rvalid & o_rready): counter++.
  - rresp!=0 sets the error flag.
  - i_rlast asserted while counter!=len, or counter==len without i_rlast, sets the error flag.
  - The burst ends on the beat with counter==len; data from an early i_rlast is still delivered.
  - End of burst -> DONE.
- AW:
  - o_awvalid=1, held until i_awready, then -> W.
  - W never starts before the AW handshake.
- W:
  - o_wvalid=i_cw_valid, o_cw_ready=i_wready, o_wdata/o_wstrb = client signals.
  - o_wlast = (counter==len).
  - On each beat: counter++.
  - The last beat -> B.
- B:
  - o_bready=1.
  - On i_bvalid, bresp!=0 sets the error flag, then -> DONE.
- DONE:
  - o_done=1 for exactly one cycle; o_err = error flag.
  - Next state IDLE. The next request is accepted no earlier than the cycle after DONE.
- Counter is 8 bits. len=255 gives 256 beats with no wrap before the last beat. len=0 gives a single beat with last=1 on the first beat.
- Backpressure: AXI valid, once asserted, is held with payload stable until ready.

Optional Feature:
- Macro AXI4FULL_MASTER_BOUNDARY_CHK_EN.
- Defined:
  - In IDLE, compute end = addr + ((len+1) << size) - 1.
  - If addr[ADDR_WIDTH-1:12] != end[ADDR_WIDTH-1:12], go straight to DONE with o_err=1.
  - No AR/AW issued; write beats are not consumed.
- Undefined: no check; the request is issued as given.

Test Plan:
- Read, addr=0x8000_0000, len=3, size=3, slave returns 4 beats with rlast on beat 4 and i_cr_ready=1 -> one arvalid handshake with arlen=3, arburst=01; 4 o_cr_valid beats with o_cr_last only on beat 4; then o_done=1, o_err=0 one cycle later.
- Write, len=1, i_awready delayed 3 cycles, i_wready toggling -> awvalid held 3 cycles with stable awaddr; wvalid not asserted before the AW handshake; wlast on beat 2 only; bresp=0 -> o_done, o_err=0.
- Read len=3 with slave asserting rlast on beat 2 and returning rresp=2'b10 on beat 1 -> o_err=1 at o_done.
- Write with bresp=2'b11 -> o_done with o_err=1; next request accepted the cycle after.
- Assert i_arsetn low during R beat 2 of 4 -> all valid/ready outputs 0 immediately; no o_done; after release, a new len=0 read completes normally.
- With AXI4FULL_MASTER_BOUNDARY_CHK_EN: read addr=0x8000_0FF0, len=3, size=3 -> o_arvalid never asserted; o_done=1, o_err=1. With addr=0x8000_0FE0 -> normal burst.

Source files
------------

// File: rtl/axi4full_burst_master_if.sv
`default_nettype none
// ============================================================================
// Module  : axi4full_burst_master_if
// Purpose : AXI4-full master-side bus bundle (no ID fields) between a burst
//           master and the downstream 2x1 arbiter port.
// Revision: 1.0 - initial release
// ============================================================================
interface axi4full_burst_master_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/axi4full_burst_master.sv
`default_nettype none
// ============================================================================
// Module  : axi4full_burst_master
// Purpose : Converts a simple client request into one AXI4 INCR burst.
//           Optional 4 KB crossing check: AXI4FULL_MASTER_BOUNDARY_CHK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module axi4full_burst_master #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  wire                   i_aclk,
    input  wire                   i_arsetn,
    input  wire                   i_req_valid,
    output logic                  o_req_ready,
    input  wire                   i_req_write,
    input  wire [ADDR_WIDTH-1:0]  i_req_addr,
    input  wire [7:0]             i_req_len,
    input  wire [2:0]             i_req_size,
    input  wire [DATA_WIDTH-1:0]  i_cw_data,
    input  wire [STRB_WIDTH-1:0]  i_cw_strb,
    input  wire                   i_cw_valid,
    output logic                  o_cw_ready,
    output logic [DATA_WIDTH-1:0] o_cr_data,
    output logic                  o_cr_valid,
    output logic                  o_cr_last,
    input  wire                   i_cr_ready,
    output logic                  o_done,
    output logic                  o_err,
    axi4full_burst_master_if.master io_axi
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW   = 3'd3,
        S_W    = 3'd4,
        S_B    = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    logic [2:0]            r_size;
    logic                  r_err;

    logic w_accept;
    logic w_beat;
    logic w_err_set;
    logic w_cross;
    logic w_cnt_last;

    assign w_cnt_last = (r_cnt == r_len);

`ifdef AXI4FULL_MASTER_BOUNDARY_CHK_EN
    logic [ADDR_WIDTH-1:0] w_span;
    logic [ADDR_WIDTH-1:0] w_end;
    // Burst byte span is at most 256 << 7, so 9 bits shifted stays in range.
    assign w_span  = {{(ADDR_WIDTH-9){1'b0}}, ({1'b0, i_req_len} + 9'd1)} << i_req_size;
    assign w_end   = i_req_addr + w_span - ADDR_WIDTH'(1);
    assign w_cross = (i_req_addr[ADDR_WIDTH-1:12] != w_end[ADDR_WIDTH-1:12]);
`else
    assign w_cross = 1'b0;
`endif

    assign io_axi.awaddr  = r_addr;
    assign io_axi.awlen   = r_len;
    assign io_axi.awsize  = r_size;
    assign io_axi.awburst = 2'b01;
    assign io_axi.awlock  = 1'b0;
    assign io_axi.awcache = 4'b0000;
    assign io_axi.awprot  = 3'b000;
    assign io_axi.araddr  = r_addr;
    assign io_axi.arlen   = r_len;
    assign io_axi.arsize  = r_size;
    assign io_axi.arburst = 2'b01;
    assign io_axi.arlock  = 1'b0;
    assign io_axi.arcache = 4'b0000;
    assign io_axi.arprot  = 3'b000;

    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr <= i_req_addr;
                r_len  <= i_req_len;
                r_size <= i_req_size;
                r_cnt  <= '0;
                r_err  <= w_cross;
            end else begin
                if (w_beat)    r_cnt <= r_cnt + 8'd1;
                if (w_err_set) r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_beat         = 1'b0;
        w_err_set      = 1'b0;
        o_req_ready    = 1'b0;
        o_cw_ready     = 1'b0;
        o_cr_data      = '0;
        o_cr_valid     = 1'b0;
        o_cr_last      = 1'b0;
        o_done         = 1'b0;
        o_err          = 1'b0;
        io_axi.awvalid = 1'b0;
        io_axi.wdata   = '0;
        io_axi.wstrb   = '0;
        io_axi.wlast   = 1'b0;
        io_axi.wvalid  = 1'b0;
        io_axi.bready  = 1'b0;
        io_axi.arvalid = 1'b0;
        io_axi.rready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_accept = 1'b1;
                    if (w_cross)          w_state_nxt = S_DONE;
                    else if (i_req_write) w_state_nxt = S_AW;
                    else                  w_state_nxt = S_AR;
                end
            end
            S_AR: begin
                io_axi.arvalid = 1'b1;
                if (io_axi.arready) w_state_nxt = S_R;
            end
            S_R: begin
                o_cr_data     = io_axi.rdata;
                o_cr_valid    = io_axi.rvalid;
                o_cr_last     = w_cnt_last;
                io_axi.rready = i_cr_ready;
                if (io_axi.rvalid && i_cr_ready) begin
                    w_beat = 1'b1;
                    // An rlast that disagrees with our own beat count is a protocol error.
                    if ((io_axi.rresp != 2'b00) || (io_axi.rlast != w_cnt_last))
                        w_err_set = 1'b1;
                    if (w_cnt_last) w_state_nxt = S_DONE;
                end
            end
            S_AW: begin
                io_axi.awvalid = 1'b1;
                if (io_axi.awready) w_state_nxt = S_W;
            end
            S_W: begin
                io_axi.wvalid = i_cw_valid;
                io_axi.wdata  = i_cw_data;
                io_axi.wstrb  = i_cw_strb;
                io_axi.wlast  = w_cnt_last;
                o_cw_ready    = io_axi.wready;
                if (i_cw_valid && io_axi.wready) begin
                    w_beat = 1'b1;
                    if (w_cnt_last) w_state_nxt = S_B;
                end
            end
            S_B: begin
                io_axi.bready = 1'b1;
                if (io_axi.bvalid) begin
                    if (io_axi.bresp != 2'b00) w_err_set = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_done      = 1'b1;
                o_err       = r_err;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4full_burst_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi4full_burst_master
// Purpose : Directed self-checking bench with a transaction-level model of
//           the burst master; also covers AXI4FULL_MASTER_BOUNDARY_CHK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi4full_burst_master;

    logic        i_aclk = 1'b0;
    logic        i_arsetn;
    logic        i_req_valid, i_req_write;
    logic [31:0] i_req_addr;
    logic [7:0]  i_req_len;
    logic [2:0]  i_req_size;
    logic [63:0] i_cw_data;
    logic [7:0]  i_cw_strb;
    logic        i_cw_valid, i_cr_ready;
    logic        o_req_ready, o_cw_ready, o_cr_valid, o_cr_last, o_done, o_err;
    logic [63:0] o_cr_data;

    axi4full_burst_master_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) axi();

    axi4full_burst_master #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut (
        .i_aclk      (i_aclk),
        .i_arsetn    (i_arsetn),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_write (i_req_write),
        .i_req_addr  (i_req_addr),
        .i_req_len   (i_req_len),
        .i_req_size  (i_req_size),
        .i_cw_data   (i_cw_data),
        .i_cw_strb   (i_cw_strb),
        .i_cw_valid  (i_cw_valid),
        .o_cw_ready  (o_cw_ready),
        .o_cr_data   (o_cr_data),
        .o_cr_valid  (o_cr_valid),
        .o_cr_last   (o_cr_last),
        .i_cr_ready  (i_cr_ready),
        .o_done      (o_done),
        .o_err       (o_err),
        .io_axi      (axi)
    );

    always #5 i_aclk = ~i_aclk;

    int n_checks = 0;
    int n_err    = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void fail(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endfunction

    function automatic logic [63:0] rpat(input int b);
        return 64'h5EED_0000_0000_0000 + 64'(b) * 64'h0000_0001_0001;
    endfunction

    function automatic logic [63:0] wpat(input int b);
        return 64'hC0DE_0000_0000_0000 | 64'(b);
    endfunction

    // Byte-span arithmetic straight from the 4 KB rule.
    function automatic bit crosses(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
`ifdef AXI4FULL_MASTER_BOUNDARY_CHK_EN
        logic [63:0] e;
        e = 64'(a) + (64'(l) + 64'd1) * (64'd1 << s) - 64'd1;
        return a[31:12] != e[31:12];
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- transaction-level model + per-cycle compare ----------
    bit          tr_open = 0, tr_wr, tr_cross, tr_bad;
    logic [31:0] tr_addr;
    logic [7:0]  tr_len;
    logic [2:0]  tr_size;
    int          n_ar, n_aw, n_rb, n_wb, n_b;

    always @(negedge i_aclk) begin
        bit exp_ar, exp_rph, exp_aw, exp_wph, exp_bph, exp_done;
        if (!i_arsetn) begin
            chk("reset_outputs", {axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready,
                                  o_cr_valid, o_cw_ready, o_done, o_err}, 64'd0);
            tr_open = 0;
        end else begin
            exp_ar   = tr_open && !tr_wr && !tr_cross && n_ar == 0;
            exp_rph  = tr_open && !tr_wr && n_ar == 1 && n_rb <= int'(tr_len);
            exp_aw   = tr_open && tr_wr && !tr_cross && n_aw == 0;
            exp_wph  = tr_open && tr_wr && n_aw == 1 && n_wb <= int'(tr_len);
            exp_bph  = tr_open && tr_wr && n_wb == int'(tr_len) + 1 && n_b == 0;
            exp_done = tr_open && (tr_cross || (tr_wr ? n_b == 1 : n_rb == int'(tr_len) + 1));

            chk("req_ready", o_req_ready, !tr_open);
            chk("arvalid", axi.arvalid, exp_ar);
            if (axi.arvalid && exp_ar)
                chk("ar_fields", {axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot},
                                 {tr_addr, tr_len, tr_size, 2'b01, 1'b0, 4'b0, 3'b0});
            chk("awvalid", axi.awvalid, exp_aw);
            if (axi.awvalid && exp_aw)
                chk("aw_fields", {axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot},
                                 {tr_addr, tr_len, tr_size, 2'b01, 1'b0, 4'b0, 3'b0});
            chk("cr_valid", o_cr_valid, exp_rph && axi.rvalid);
            chk("rready", axi.rready, exp_rph && i_cr_ready);
            if (o_cr_valid && exp_rph) begin
                chk("cr_data", o_cr_data, axi.rdata);
                chk("cr_last", o_cr_last, n_rb == int'(tr_len));
            end
            chk("wvalid", axi.wvalid, exp_wph && i_cw_valid);
            chk("cw_ready", o_cw_ready, exp_wph && axi.wready);
            if (axi.wvalid && exp_wph) begin
                chk("wdata", axi.wdata, i_cw_data);
                chk("wstrb", axi.wstrb, i_cw_strb);
                chk("wlast", axi.wlast, n_wb == int'(tr_len));
            end
            chk("bready", axi.bready, exp_bph);
            chk("done", o_done, exp_done);
            if (o_done && exp_done) chk("done_err", o_err, tr_cross || tr_bad);

            // advance the model by what the next clock edge will consume
            if (exp_ar && axi.arready) n_ar++;
            if (exp_aw && axi.awready) n_aw++;
            if (exp_rph && axi.rvalid && i_cr_ready) begin
                if (axi.rresp != 2'b00 || axi.rlast != (n_rb == int'(tr_len))) tr_bad = 1;
                n_rb++;
            end
            if (exp_wph && i_cw_valid && axi.wready) n_wb++;
            if (exp_bph && axi.bvalid) begin
                if (axi.bresp != 2'b00) tr_bad = 1;
                n_b++;
            end
            if (exp_done) tr_open = 0;
            else if (!tr_open && i_req_valid) begin
                tr_open = 1; tr_wr = i_req_write; tr_addr = i_req_addr;
                tr_len = i_req_len; tr_size = i_req_size; tr_bad = 0;
                tr_cross = crosses(i_req_addr, i_req_len, i_req_size);
                n_ar = 0; n_aw = 0; n_rb = 0; n_wb = 0; n_b = 0;
            end
        end
    end

    // ---------------- directed stimulus ------------------------------------
    int t_err, t_done_seen, t_done_wait, t_addr_wait, t_beats, t_lasts, t_acc_wait;

    task automatic cyc();
        @(posedge i_aclk);
        #1;
    endtask

    task automatic txn(input bit wr, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                       input int addr_dly, input int rlast_at, input int bad_at, input logic [1:0] bad_resp,
                       input bit tgl, input logic [1:0] bresp, input bit issue, input int rst_at);
        bit hs;
        int tc;
        tc = 0;
        t_err = 0; t_done_seen = 0; t_done_wait = -1; t_addr_wait = 0;
        t_beats = 0; t_lasts = 0; t_acc_wait = -1;
        i_req_valid = 1; i_req_write = wr; i_req_addr = addr; i_req_len = len; i_req_size = size;
        if (wr) begin i_cw_valid = 1; i_cw_data = wpat(0); i_cw_strb = 8'hFF; end
        for (int k = 0; k < 20; k++) begin
            @(negedge i_aclk); hs = o_req_ready; cyc();
            if (hs) begin t_acc_wait = k; break; end
        end
        i_req_valid = 0;
        if (t_acc_wait < 0) begin fail("accept"); i_cw_valid = 0; return; end
        if (issue) begin
            hs = 0;
            for (int k = 0; k < 50; k++) begin
                if (wr) axi.awready = (k >= addr_dly); else axi.arready = (k >= addr_dly);
                @(negedge i_aclk);
                hs = wr ? (axi.awvalid && axi.awready) : (axi.arvalid && axi.arready);
                if ((wr ? axi.awvalid : axi.arvalid) && !hs) t_addr_wait++;
                cyc();
                if (hs) break;
            end
            axi.awready = 0; axi.arready = 0;
            if (!hs) begin fail("addr_handshake"); i_cw_valid = 0; return; end
            for (int b = 0; b <= int'(len); b++) begin
                if (wr) begin
                    i_cw_data = wpat(b); i_cw_strb = 8'hFF >> (b % 8); i_cw_valid = 1;
                end else begin
                    axi.rvalid = 1; axi.rdata = rpat(b);
                    axi.rresp = (b == bad_at) ? bad_resp : 2'b00;
                    axi.rlast = (b == rlast_at);
                end
                if (!wr && b == rst_at) begin
                    i_cr_ready = 1;
                    @(negedge i_aclk);
                    chk("pre_reset_cr_valid", o_cr_valid, 1);
                    #1 i_arsetn = 0;
                    #1 chk("async_reset_outs", {axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready,
                                                o_cr_valid, o_cw_ready, o_done, o_err}, 64'd0);
                    axi.rvalid = 0; axi.rlast = 0; i_cr_ready = 0;
                    repeat (3) cyc();
                    i_arsetn = 1;
                    for (int j = 0; j < 4; j++) begin
                        @(negedge i_aclk); chk("no_done_after_reset", o_done, 0); cyc();
                    end
                    return;
                end
                hs = 0;
                for (int k = 0; k < 20; k++) begin
                    tc++;
                    if (wr) axi.wready = !tgl || tc[0]; else i_cr_ready = !tgl || tc[0];
                    @(negedge i_aclk);
                    hs = wr ? (axi.wvalid && axi.wready) : (o_cr_valid && i_cr_ready);
                    if (hs) begin
                        t_beats++;
                        if (wr ? axi.wlast : o_cr_last) t_lasts++;
                    end
                    cyc();
                    if (hs) break;
                end
                if (!hs) begin
                    fail("data_beat");
                    axi.rvalid = 0; i_cw_valid = 0; axi.wready = 0; i_cr_ready = 0;
                    return;
                end
            end
            axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0; i_cw_valid = 0; axi.wready = 0; i_cr_ready = 0;
            if (wr) begin
                axi.bvalid = 1; axi.bresp = bresp; hs = 0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge i_aclk); hs = axi.bready; cyc();
                    if (hs) break;
                end
                axi.bvalid = 0; axi.bresp = 0;
                if (!hs) begin fail("b_handshake"); return; end
            end
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge i_aclk);
            if (o_done) begin t_done_seen = 1; t_err = o_err; t_done_wait = k; cyc(); break; end
            cyc();
        end
        i_cw_valid = 0;
        if (!t_done_seen) fail("done_wait");
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation bound expired");
        $fatal(1, "global timeout");
    end

    initial begin
        i_arsetn = 0; i_req_valid = 0; i_req_write = 0; i_req_addr = 0; i_req_len = 0; i_req_size = 0;
        i_cw_data = 0; i_cw_strb = 0; i_cw_valid = 0; i_cr_ready = 0;
        axi.awready = 0; axi.wready = 0; axi.bresp = 0; axi.bvalid = 0; axi.arready = 0;
        axi.rdata = 0; axi.rresp = 0; axi.rlast = 0; axi.rvalid = 0;
        repeat (3) cyc();
        i_arsetn = 1;
        @(negedge i_aclk); chk("idle_req_ready", o_req_ready, 1);
        cyc();

        // 4-beat read, slave well behaved
        txn(0, 32'h8000_0000, 8'd3, 3'd3, 0, 3, -1, 2'b00, 0, 2'b00, 1, -1);
        chk("t1_beats", t_beats, 4); chk("t1_lasts", t_lasts, 1);
        chk("t1_err", t_err, 0); chk("t1_done_lat", t_done_wait, 0); chk("t1_ar_wait", t_addr_wait, 0);

        // 2-beat write, awready late by 3 cycles, wready toggling
        txn(1, 32'h0000_2000, 8'd1, 3'd3, 3, 0, -1, 2'b00, 1, 2'b00, 1, -1);
        chk("t2_aw_wait", t_addr_wait, 3); chk("t2_beats", t_beats, 2);
        chk("t2_lasts", t_lasts, 1); chk("t2_err", t_err, 0);

        // early rlast plus SLVERR on first beat
        txn(0, 32'h0000_3000, 8'd3, 3'd3, 1, 1, 0, 2'b10, 1, 2'b00, 1, -1);
        chk("t3_beats", t_beats, 4); chk("t3_lasts", t_lasts, 1); chk("t3_err", t_err, 1);

        // DECERR write response, then back-to-back request
        txn(1, 32'h0000_4000, 8'd0, 3'd2, 1, 0, -1, 2'b00, 0, 2'b11, 1, -1);
        chk("t4_err", t_err, 1); chk("t4_lasts", t_lasts, 1);
        txn(0, 32'h0000_4100, 8'd0, 3'd3, 0, 0, -1, 2'b00, 0, 2'b00, 1, -1);
        chk("t4b_acc_wait", t_acc_wait, 0); chk("t4b_err", t_err, 0);

        // reset in the middle of beat 2 of 4, then a single-beat read
        txn(0, 32'h0000_5000, 8'd3, 3'd3, 0, 3, -1, 2'b00, 0, 2'b00, 1, 1);
        chk("t5_no_done", t_done_seen, 0);
        txn(0, 32'h0000_5100, 8'd0, 3'd3, 0, 0, -1, 2'b00, 0, 2'b00, 1, -1);
        chk("t5b_beats", t_beats, 1); chk("t5b_lasts", t_lasts, 1); chk("t5b_err", t_err, 0);

        // longest burst: 256 beats
        txn(0, 32'h0001_0000, 8'd255, 3'd0, 0, 255, -1, 2'b00, 0, 2'b00, 1, -1);
        chk("t6_beats", t_beats, 256); chk("t6_lasts", t_lasts, 1); chk("t6_err", t_err, 0);

`ifdef AXI4FULL_MASTER_BOUNDARY_CHK_EN
        txn(0, 32'h8000_0FF0, 8'd3, 3'd3, 0, 3, -1, 2'b00, 0, 2'b00, 0, -1);
        chk("t7_cross_err", t_err, 1); chk("t7_cross_lat", t_done_wait, 0);
        txn(1, 32'h8000_0FF8, 8'd1, 3'd3, 0, 0, -1, 2'b00, 0, 2'b00, 0, -1);
        chk("t7_wcross_err", t_err, 1);
        txn(0, 32'h8000_0FE0, 8'd3, 3'd3, 0, 3, -1, 2'b00, 0, 2'b00, 1, -1);
        chk("t7_fit_beats", t_beats, 4); chk("t7_fit_err", t_err, 0);
`else
        txn(0, 32'h8000_0FF0, 8'd3, 3'd3, 0, 3, -1, 2'b00, 0, 2'b00, 1, -1);
        chk("t7_nochk_beats", t_beats, 4); chk("t7_nochk_err", t_err, 0);
`endif

        repeat (3) cyc();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
